ds_alu_seq: RTL

DS_ALU_SEQ -- requirements
Module: ds_alu_seq

---
 rtl/ds_alu_seq.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ds_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ds_alu_seq
//  Description : Forth-style ALU sequencer. Holds TOS locally and drives an
//                external data stack (clear/push/pop) for NOS traffic.
//                Optional sticky error flags under macro DS_ALU_SEQ_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ds_alu_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] opcode,
    input  logic [7:0] lit,
    output logic [1:0] ds_mode,
    output logic [7:0] ds_wdata,
    output logic       ds_oe,
    input  logic [7:0] ds_rdata,
    output logic [7:0] tos,
    output logic [8:0] depth,
    output logic       done,
    output logic       err_uflow,
    output logic       err_oflow
);

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_POP  = 3'd2,
        ST_WAIT = 3'd3,
        ST_PUSH = 3'd4
    } state_t;

    localparam logic [3:0] C_OP_LIT   = 4'h1;
    localparam logic [3:0] C_OP_DROP  = 4'h2;
    localparam logic [3:0] C_OP_DUP   = 4'h3;
    localparam logic [3:0] C_OP_ADD   = 4'h4;
    localparam logic [3:0] C_OP_SUB   = 4'h5;
    localparam logic [3:0] C_OP_AND   = 4'h6;
    localparam logic [3:0] C_OP_OR    = 4'h7;
    localparam logic [3:0] C_OP_XOR   = 4'h8;
    localparam logic [3:0] C_OP_SWAP  = 4'h9;
    localparam logic [3:0] C_OP_NOT   = 4'hA;
    localparam logic [3:0] C_OP_CLEAR = 4'hB;

    localparam logic [1:0] C_DS_CLR  = 2'd0;
    localparam logic [1:0] C_DS_PUSH = 2'd1;
    localparam logic [1:0] C_DS_POP  = 2'd2;
    localparam logic [1:0] C_DS_IDLE = 2'd3;

    localparam logic [8:0] C_DEPTH_MAX = 9'd257;

`ifdef DS_ALU_SEQ_ERR_EN
    localparam logic C_ERR_EN = 1'b1;
`else
    localparam logic C_ERR_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] tos_q, tos_d;
    logic [8:0] depth_q, depth_d;
    logic [7:0] ds_wdata_q, ds_wdata_d;
    logic [1:0] ds_mode_q, ds_mode_d;
    logic       ds_oe_q, ds_oe_d;
    logic       op_ready_q, op_ready_d;
    logic       done_q, done_d;
    logic       clr_done_q, clr_done_d;   // CLR entered by CLEAR (pulses done) vs reset
    logic       err_uflow_q, err_uflow_d;
    logic       err_oflow_q, err_oflow_d;

    logic       w_accept;
    logic [7:0] w_push_val;
    logic       w_uflow_ev;
    logic       w_oflow_ev;
    logic       w_clear_ev;

    // Next-state, datapath and registered-output decode for the sequencer
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tos_d      = tos_q;
        depth_d    = depth_q;
        ds_wdata_d = ds_wdata_q;
        done_d     = 1'b0;
        clr_done_d = clr_done_q;
        w_uflow_ev = 1'b0;
        w_oflow_ev = 1'b0;
        w_clear_ev = 1'b0;
        w_accept   = op_valid && op_ready_q;
        w_push_val = (opcode == C_OP_LIT) ? lit : tos_q;

        case (state_q)
            ST_CLR: begin
                state_d    = ST_IDLE;
                done_d     = clr_done_q;
                clr_done_d = 1'b0;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    op_d = opcode;
                    case (opcode)
                        C_OP_LIT, C_OP_DUP: begin
                            if (depth_q == C_DEPTH_MAX) begin
                                w_oflow_ev = 1'b1;
                                done_d     = 1'b1;
                            end else if (depth_q == 9'd0) begin
                                // Empty stack: value lives only in TOS
                                tos_d   = w_push_val;
                                depth_d = 9'd1;
                                done_d  = 1'b1;
                            end else begin
                                state_d    = ST_PUSH;
                                ds_wdata_d = tos_q;
                                tos_d      = w_push_val;
                                depth_d    = depth_q + 9'd1;
                            end
                        end
                        C_OP_DROP: begin
                            if (depth_q == 9'd0) begin
                                w_uflow_ev = 1'b1;
                                done_d     = 1'b1;
                            end else if (depth_q == 9'd1) begin
                                tos_d   = 8'd0;
                                depth_d = 9'd0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
                        C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_XOR, C_OP_SWAP: begin
                            if (depth_q < 9'd2) begin
                                w_uflow_ev = 1'b1;
                                done_d     = 1'b1;
                            end else begin
                                state_d = ST_POP;
                            end
                        end
                        C_OP_NOT: begin
                            tos_d  = ~tos_q;
                            done_d = 1'b1;
                        end
                        C_OP_CLEAR: begin
                            state_d    = ST_CLR;
                            tos_d      = 8'd0;
                            depth_d    = 9'd0;
                            clr_done_d = 1'b1;
                            w_clear_ev = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_POP: state_d = ST_WAIT;
            ST_WAIT: begin
                // ds_rdata holds NOS during this cycle
                state_d = ST_IDLE;
                done_d  = 1'b1;
                depth_d = depth_q - 9'd1;
                case (op_q)
                    C_OP_DROP: tos_d = ds_rdata;
                    C_OP_ADD:  tos_d = ds_rdata + tos_q;
                    C_OP_SUB:  tos_d = ds_rdata - tos_q;
                    C_OP_AND:  tos_d = ds_rdata & tos_q;
                    C_OP_OR:   tos_d = ds_rdata | tos_q;
                    C_OP_XOR:  tos_d = ds_rdata ^ tos_q;
                    C_OP_SWAP: begin
                        state_d    = ST_PUSH;
                        done_d     = 1'b0;
                        depth_d    = depth_q;
                        ds_wdata_d = tos_q;
                        tos_d      = ds_rdata;
                    end
                    default: depth_d = depth_q;
                endcase
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_CLR;
        endcase

        case (state_d)
            ST_CLR:  ds_mode_d = C_DS_CLR;
            ST_POP:  ds_mode_d = C_DS_POP;
            ST_PUSH: ds_mode_d = C_DS_PUSH;
            default: ds_mode_d = C_DS_IDLE;
        endcase
        ds_oe_d    = (state_d == ST_PUSH);
        op_ready_d = (state_d == ST_IDLE);

        err_uflow_d = w_clear_ev ? 1'b0 : (err_uflow_q | w_uflow_ev);
        err_oflow_d = w_clear_ev ? 1'b0 : (err_oflow_q | w_oflow_ev);
    end

    // State and output registers; reset abandons any in-flight operation
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CLR;
            op_q        <= 4'd0;
            tos_q       <= 8'd0;
            depth_q     <= 9'd0;
            ds_wdata_q  <= 8'd0;
            ds_mode_q   <= C_DS_CLR;
            ds_oe_q     <= 1'b0;
            op_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            clr_done_q  <= 1'b0;
            err_uflow_q <= 1'b0;
            err_oflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tos_q       <= tos_d;
            depth_q     <= depth_d;
            ds_wdata_q  <= ds_wdata_d;
            ds_mode_q   <= ds_mode_d;
            ds_oe_q     <= ds_oe_d;
            op_ready_q  <= op_ready_d;
            done_q      <= done_d;
            clr_done_q  <= clr_done_d;
            err_uflow_q <= err_uflow_d;
            err_oflow_q <= err_oflow_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign ds_mode   = ds_mode_q;
    assign ds_wdata  = ds_wdata_q;
    assign ds_oe     = ds_oe_q;
    assign tos       = tos_q;
    assign depth     = depth_q;
    assign done      = done_q;
    assign err_uflow = err_uflow_q & C_ERR_EN;
    assign err_oflow = err_oflow_q & C_ERR_EN;

endmodule
`default_nettype wire
